// File: rtl/lc3b_types.sv
// Shared LC-3b memory types.
//   lc3b_word  : 16-bit address/data word
//   lc3b_block : 128-bit cache line moved between a cache and physical memory
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

endpackage

// File: rtl/cache_arbiter_if.sv
// Signal bundle for the cache arbiter: I-cache side, D-cache side and the
// shared physical-memory side.
//   master : the environment view (caches and memory drive the arbiter inputs)
//   slave  : the arbiter view
// Handshake: a requester raises read/write with address (and wdata) and holds
// them until it sees its resp high for one cycle; it drops the request at that
// edge. Memory holds pmem_resp high for one cycle per operation, and rdata is
// valid only while the matching resp is high.
interface cache_arbiter_if;
  import lc3b_types::*;

  logic      icache_pmem_read;
  lc3b_word  icache_pmem_address;
  lc3b_block icache_pmem_rdata;
  logic      icache_pmem_resp;

  logic      dcache_pmem_read;
  logic      dcache_pmem_write;
  lc3b_word  dcache_pmem_address;
  lc3b_block dcache_pmem_wdata;
  lc3b_block dcache_pmem_rdata;
  logic      dcache_pmem_resp;

  logic      pmem_read;
  logic      pmem_write;
  lc3b_word  pmem_address;
  lc3b_block pmem_wdata;
  lc3b_block pmem_rdata;
  logic      pmem_resp;

  modport master (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and the D-cache with at
// most one memory operation in flight. D-cache has priority, but after
// STARVE_LIMIT consecutive D grants made while the I-cache was waiting, the
// I-cache wins the next grant.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   icache_pmem_*         : I-cache read request / response
//   dcache_pmem_*         : D-cache read/write request / response
//   pmem_*                : physical-memory port
//   state_dbg             : current FSM state (0 idle, 1 icache, 2 dcache)
//   starve_count          : starvation counter
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst_n,

  input  logic      icache_pmem_read,
  input  lc3b_word  icache_pmem_address,
  output lc3b_block icache_pmem_rdata,
  output logic      icache_pmem_resp,

  input  logic      dcache_pmem_read,
  input  logic      dcache_pmem_write,
  input  lc3b_word  dcache_pmem_address,
  input  lc3b_block dcache_pmem_wdata,
  output lc3b_block dcache_pmem_rdata,
  output logic      dcache_pmem_resp,

  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  pmem_address,
  output lc3b_block pmem_wdata,
  input  lc3b_block pmem_rdata,
  input  logic      pmem_resp,

  output logic [1:0]                        state_dbg,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_count
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ICACHE = 2'd1,
    S_DCACHE = 2'd2
  } state_t;

  state_t    state_q, state_d;
  logic [CW-1:0] starve_q;
  lc3b_word  addr_q;
  lc3b_block wdata_q;
  logic      write_q;

  logic d_req, i_req, i_wins;

  assign d_req  = dcache_pmem_read | dcache_pmem_write;
  assign i_req  = icache_pmem_read;
  // I-cache wins when D is quiet, or when D has had its full run of grants.
  assign i_wins = i_req && (!d_req || (starve_q == LIMIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_wins)     state_d = S_ICACHE;
        else if (d_req) state_d = S_DCACHE;
      end
      S_ICACHE, S_DCACHE: begin
        // Always pass through idle after a response, so a request still high
        // in that cycle is arbitrated as a fresh one.
        if (pmem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant-time capture of the winner's operation and the starvation counter.
  // Nothing here changes while a grant is active, so requester-side changes
  // mid-operation cannot reach the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      starve_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (i_wins) begin
        addr_q   <= icache_pmem_address;
        wdata_q  <= '0;
        write_q  <= 1'b0;
        starve_q <= '0;
      end else if (d_req) begin
        addr_q   <= dcache_pmem_address;
        wdata_q  <= dcache_pmem_wdata;
        // Read and write together is illegal; write takes precedence.
        write_q  <= dcache_pmem_write;
        if (!i_req)                starve_q <= '0;
        else if (starve_q != LIMIT) starve_q <= starve_q + CW'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state_q)
      S_ICACHE: begin
        pmem_read        = ~write_q;
        pmem_write       = write_q;
        icache_pmem_resp = pmem_resp;
      end
      S_DCACHE: begin
        pmem_read        = ~write_q;
        pmem_write       = write_q;
        dcache_pmem_resp = pmem_resp;
      end
      default: ;
    endcase
  end

  assign pmem_address      = addr_q;
  assign pmem_wdata        = wdata_q;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;
  assign state_dbg         = state_q;
  assign starve_count      = starve_q;

  illegal_dcache_op: assert property (
    @(posedge clk) disable iff (!rst_n) !(dcache_pmem_read && dcache_pmem_write)
  ) else $warning("cache_arbiter: dcache read and write both high, write takes precedence");

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with a grant scoreboard, a
// latency-programmable memory model and auto-dropping requesters.
module tb_cache_arbiter;
  import lc3b_types::*;

  // Scoreboard entry: {who_icache, write, read, address, wdata}
  localparam int W = 1 + 1 + 1 + 16 + 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if bus();
  logic [1:0] state_dbg;
  logic [2:0] starve_count;

  cache_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (bus.icache_pmem_read),
    .icache_pmem_address (bus.icache_pmem_address),
    .icache_pmem_rdata   (bus.icache_pmem_rdata),
    .icache_pmem_resp    (bus.icache_pmem_resp),
    .dcache_pmem_read    (bus.dcache_pmem_read),
    .dcache_pmem_write   (bus.dcache_pmem_write),
    .dcache_pmem_address (bus.dcache_pmem_address),
    .dcache_pmem_wdata   (bus.dcache_pmem_wdata),
    .dcache_pmem_rdata   (bus.dcache_pmem_rdata),
    .dcache_pmem_resp    (bus.dcache_pmem_resp),
    .pmem_read           (bus.pmem_read),
    .pmem_write          (bus.pmem_write),
    .pmem_address        (bus.pmem_address),
    .pmem_wdata          (bus.pmem_wdata),
    .pmem_rdata          (bus.pmem_rdata),
    .pmem_resp           (bus.pmem_resp),
    .state_dbg           (state_dbg),
    .starve_count        (starve_count)
  );

  // ---------------- bench state ----------------
  int tests_run = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  bit  cur_valid = 0;
  bit  prev_active = 0;
  int  op_cycles = 0;
  int  idle_run = 0;
  int  last_gap = 0;
  int  mem_lat = 3;
  int  mem_cnt = 0;
  int  i_resp_cnt = 0;
  int  d_resp_cnt = 0;
  bit  i_auto = 1;
  bit  d_auto = 1;

  function automatic logic [W-1:0] mk(input bit who_i, input bit wr, input lc3b_word a,
                                       input lc3b_block wd);
    return {who_i, wr, ~wr, a, wd};
  endfunction

  // ---------------- driver / monitor step ----------------
  // One clock cycle: check the port at the falling edge, advance the memory
  // model, then let requesters react to a response.
  task automatic step();
    bit active;
    bit exp_i;
    bit exp_d;
    @(negedge clk);
    active = bus.pmem_read | bus.pmem_write;
    if (active && !prev_active) begin
      if (exp_q.size() == 0) begin
        tests_run++; fails++;
        $display("FAIL grant_unexpected: addr=%h write=%b, required no grant",
                 bus.pmem_address, bus.pmem_write);
        cur_valid = 0;
      end else begin
        cur_exp = exp_q.pop_front();
        cur_valid = 1;
      end
      op_cycles = 0;
      last_gap = idle_run;
    end
    if (active) begin
      op_cycles++;
      idle_run = 0;
      if (cur_valid) begin
        tests_run++;
        if ({bus.pmem_write, bus.pmem_read, bus.pmem_address} !== cur_exp[W-2 -: 18]) begin
          fails++;
          $display("FAIL grant_op: got wr=%b rd=%b addr=%h, required wr=%b rd=%b addr=%h",
                   bus.pmem_write, bus.pmem_read, bus.pmem_address,
                   cur_exp[W-2], cur_exp[W-3], cur_exp[143:128]);
        end
        if (cur_exp[W-2]) begin
          tests_run++;
          if (bus.pmem_wdata !== cur_exp[127:0]) begin
            fails++;
            $display("FAIL grant_wdata: got %h, required %h", bus.pmem_wdata, cur_exp[127:0]);
          end
        end
      end
    end else begin
      idle_run++;
    end
    prev_active = active;

    // memory model
    if (!rst_n || bus.pmem_resp) begin
      bus.pmem_resp = 1'b0;
      mem_cnt = 0;
    end else if (active) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        bus.pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.pmem_resp = 1'b1;
      end
    end
    #1;

    exp_i = active && cur_valid &&  cur_exp[W-1] && bus.pmem_resp;
    exp_d = active && cur_valid && !cur_exp[W-1] && bus.pmem_resp;
    tests_run++;
    if ({bus.icache_pmem_resp, bus.dcache_pmem_resp} !== {exp_i, exp_d}) begin
      fails++;
      $display("FAIL resp_route: got i=%b d=%b, required i=%b d=%b",
               bus.icache_pmem_resp, bus.dcache_pmem_resp, exp_i, exp_d);
    end
    tests_run++;
    if (bus.icache_pmem_rdata !== bus.pmem_rdata || bus.dcache_pmem_rdata !== bus.pmem_rdata) begin
      fails++;
      $display("FAIL rdata_pass: got i=%h d=%h, required %h",
               bus.icache_pmem_rdata, bus.dcache_pmem_rdata, bus.pmem_rdata);
    end

    if (bus.icache_pmem_resp) begin
      i_resp_cnt++;
      if (i_auto) bus.icache_pmem_read = 1'b0;
    end
    if (bus.dcache_pmem_resp) begin
      d_resp_cnt++;
      if (d_auto) begin
        bus.dcache_pmem_read = 1'b0;
        bus.dcache_pmem_write = 1'b0;
      end
    end
  endtask

  task automatic wait_counts(input int ti, input int td, input int budget, input string name);
    int n = 0;
    while ((i_resp_cnt < ti || d_resp_cnt < td) && n < budget) begin
      step();
      n++;
    end
    tests_run++;
    if (i_resp_cnt < ti || d_resp_cnt < td) begin
      fails++;
      $display("FAIL %s_timeout: got i_resp=%0d d_resp=%0d, required %0d %0d",
               name, i_resp_cnt, d_resp_cnt, ti, td);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = 16'h1111;
    step();
    step();
    tests_run++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
         bus.icache_pmem_resp, bus.dcache_pmem_resp, state_dbg, starve_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h state=%0d cnt=%0d, required all 0",
               bus.pmem_read, bus.pmem_write, bus.pmem_address, state_dbg, starve_count);
    end
    bus.icache_pmem_read = 1'b0;
    rst_n = 1'b1;
    step();
    tests_run++;
    if (state_dbg !== 2'd0 || bus.pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got state=%0d rd=%b, required 0 0", state_dbg, bus.pmem_read);
    end
  endtask

  task automatic test_i_only();
    int i0 = i_resp_cnt;
    int d0 = d_resp_cnt;
    mem_lat = 5;
    bus.icache_pmem_address = 16'h1230;
    bus.icache_pmem_read = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 16'h1230, '0));
    wait_counts(i0 + 1, d0, 30, "i_only");
    tests_run++;
    if (op_cycles != 5) begin
      fails++;
      $display("FAIL i_only_len: got %0d busy cycles, required 5", op_cycles);
    end
    step();
    step();
    tests_run++;
    if (i_resp_cnt != i0 + 1 || d_resp_cnt != d0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL i_only_resp: got i=%0d d=%0d state=%0d, required %0d %0d 0",
               i_resp_cnt - i0, d_resp_cnt - d0, state_dbg, 1, 0);
    end
  endtask

  task automatic test_simultaneous();
    int i0 = i_resp_cnt;
    int d0 = d_resp_cnt;
    mem_lat = 3;
    bus.icache_pmem_address = 16'h0040;
    bus.icache_pmem_read = 1'b1;
    bus.dcache_pmem_address = 16'h8000;
    bus.dcache_pmem_read = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h8000, '0));
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0040, '0));
    wait_counts(i0 + 1, d0 + 1, 40, "simul");
    tests_run++;
    if (last_gap != 1) begin
      fails++;
      $display("FAIL simul_gap: got %0d idle cycles, required 1", last_gap);
    end
    tests_run++;
    if (starve_count !== 3'd0) begin
      fails++;
      $display("FAIL simul_count: got %0d, required 0", starve_count);
    end
  endtask

  task automatic test_starvation();
    int i0 = i_resp_cnt;
    int d0 = d_resp_cnt;
    lc3b_word da;
    da = 16'($urandom_range(16'h2000, 16'h2FFF));
    mem_lat = 2;
    d_auto = 0;
    bus.icache_pmem_address = 16'h0100;
    bus.icache_pmem_read = 1'b1;
    bus.dcache_pmem_address = da;
    bus.dcache_pmem_read = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, 1'b0, da, '0));
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0100, '0));
    exp_q.push_back(mk(1'b0, 1'b0, da, '0));
    wait_counts(i0, d0 + 4, 60, "starve_d");
    tests_run++;
    if (starve_count !== 3'd4) begin
      fails++;
      $display("FAIL starve_sat: got %0d, required 4", starve_count);
    end
    wait_counts(i0 + 1, d0 + 4, 20, "starve_i");
    tests_run++;
    if (starve_count !== 3'd0 || d_resp_cnt != d0 + 4) begin
      fails++;
      $display("FAIL starve_turn: got cnt=%0d d_grants=%0d, required 0 4",
               starve_count, d_resp_cnt - d0);
    end
    d_auto = 1;
    wait_counts(i0 + 1, d0 + 5, 20, "starve_tail");
    tests_run++;
    if (starve_count !== 3'd0) begin
      fails++;
      $display("FAIL starve_clear: got %0d, required 0", starve_count);
    end
  endtask

  task automatic test_write_back();
    int d0 = d_resp_cnt;
    lc3b_block a5;
    a5 = {16{8'hA5}};
    mem_lat = 6;
    bus.dcache_pmem_address = 16'h3FF0;
    bus.dcache_pmem_wdata = a5;
    bus.dcache_pmem_write = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 16'h3FF0, a5));
    step();
    step();
    step();
    bus.dcache_pmem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.dcache_pmem_address = 16'h1111;
    wait_counts(i_resp_cnt, d0 + 1, 30, "wb");
    tests_run++;
    if (op_cycles != 6) begin
      fails++;
      $display("FAIL wb_len: got %0d busy cycles, required 6", op_cycles);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int i0 = i_resp_cnt;
    int d0 = d_resp_cnt;
    int n = 0;
    mem_lat = 10;
    bus.dcache_pmem_address = 16'h5000;
    bus.dcache_pmem_read = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h5000, '0));
    while (!(prev_active && op_cycles == 3) && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (!(prev_active && op_cycles == 3)) begin
      fails++;
      $display("FAIL rst_mid_reach: got busy=%b cycles=%0d, required 1 3", prev_active, op_cycles);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.dcache_pmem_resp, state_dbg} !== '0) begin
      fails++;
      $display("FAIL rst_mid_drop: got rd=%b wr=%b addr=%h resp=%b state=%0d, required all 0",
               bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.dcache_pmem_resp, state_dbg);
    end
    cur_valid = 0;
    bus.icache_pmem_address = 16'h0200;
    bus.icache_pmem_read = 1'b1;
    step();
    step();
    tests_run++;
    if (d_resp_cnt != d0 || i_resp_cnt != i0) begin
      fails++;
      $display("FAIL rst_mid_noresp: got d=%0d i=%0d, required 0 0", d_resp_cnt - d0, i_resp_cnt - i0);
    end
    mem_lat = 2;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h5000, '0));
    exp_q.push_back(mk(1'b1, 1'b0, 16'h0200, '0));
    rst_n = 1'b1;
    wait_counts(i0 + 1, d0 + 1, 40, "rst_mid_after");
  endtask

  task automatic test_illegal();
    int d0 = d_resp_cnt;
    lc3b_block wd;
    wd = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem_lat = 2;
    bus.dcache_pmem_address = 16'h7777;
    bus.dcache_pmem_wdata = wd;
    bus.dcache_pmem_read = 1'b1;
    bus.dcache_pmem_write = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 16'h7777, wd));
    wait_counts(i_resp_cnt, d0 + 1, 20, "illegal");
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.icache_pmem_read = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp = 1'b0;

    test_reset();
    test_i_only();
    test_simultaneous();
    test_starvation();
    test_write_back();
    test_reset_mid_op();
    test_illegal();
    step();
    step();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d grants outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
